// File: rtl/framebuffer_store.sv
// 64x48 4-bit pixel framebuffer, 8 pixels per 32-bit word, with a host write FIFO
// and a whole-frame clear engine. Feeder reads are combinational and never blocked.
module framebuffer_store #(
    parameter int FIFO_DEPTH = 4,
    parameter int H_PIX      = 64,
    parameter int V_PIX      = 48
) (
    input  logic       clk_25,
    input  logic       rst,
    input  logic [8:0] addr,
    input  logic [2:0] pix_sel,
    input  logic       mem_read,
    output logic [3:0] pixel_in,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [5:0] wr_x,
    input  logic [5:0] wr_y,
    input  logic [3:0] wr_pix,
    input  logic       clr_req,
    input  logic [3:0] clr_colour,
    output logic       clr_busy,
    output logic       wr_err,
    input  logic       err_clr
);

    localparam int             WORDS     = (H_PIX / 8) * V_PIX;
    localparam int             PW        = $clog2(FIFO_DEPTH);
    localparam logic [8:0]     LAST_WORD = 9'(WORDS - 1);
    localparam logic [5:0]     Y_LIMIT   = 6'(V_PIX);
    localparam logic [PW:0]    FULL_CNT  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]    CNT_ONE   = (PW + 1)'(1);
    localparam logic [PW-1:0]  PTR_ONE   = PW'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    logic [31:0]   r_mem  [0:WORDS-1];
    logic [15:0]   r_fifo [0:FIFO_DEPTH-1];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    state_t        r_state;
    logic [8:0]    r_clr_cnt;
    logic [3:0]    r_colour;
    logic          r_clr_busy;
    logic          r_wr_err;

    logic          w_push;
    logic          w_store;
    logic          w_range_err;
    logic          w_pop;
    logic          w_clr_wr;
    logic [15:0]   w_head;
    logic [8:0]    w_head_word;
    logic [31:0]   w_merged;
    logic [31:0]   w_rd_word;

    assign wr_ready    = (r_count != FULL_CNT);
    assign clr_busy    = r_clr_busy;
    assign wr_err      = r_wr_err;

    assign w_push      = wr_valid && wr_ready;
    assign w_store     = w_push && (wr_y < Y_LIMIT);
    assign w_range_err = w_push && !(wr_y < Y_LIMIT);
    // Clear request in IDLE wins over a pop; mem_read blocks every array write.
    assign w_pop       = (r_state == S_IDLE) && !clr_req && !mem_read &&
                         (r_count != {(PW + 1){1'b0}});
    assign w_clr_wr    = (r_state == S_CLEAR) && !mem_read;

    assign w_head      = r_fifo[r_rptr];
    assign w_head_word = {w_head[15:10], w_head[9:7]};

    // Read-modify-write merge of the head pixel into its word
    always_comb begin
        w_merged = r_mem[w_head_word];
        w_merged[{w_head[6:4], 2'b00} +: 4] = w_head[3:0];
    end

    // Feeder read path: zero-latency nibble select, zero beyond the frame
    always_comb begin
        if (addr <= LAST_WORD) begin
            w_rd_word = r_mem[addr];
        end else begin
            w_rd_word = 32'd0;
        end
        pixel_in = w_rd_word[{pix_sel, 2'b00} +: 4];
    end

    // Unreset storage: pixel array and FIFO entries
    always_ff @(posedge clk_25) begin
        if (!rst && w_clr_wr) begin
            r_mem[r_clr_cnt] <= {8{r_colour}};
        end else if (!rst && w_pop) begin
            r_mem[w_head_word] <= w_merged;
        end
        if (w_store) begin
            r_fifo[r_wptr] <= {wr_y, wr_x, wr_pix};
        end
    end

    // FIFO bookkeeping, sticky error flag and clear FSM
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            r_wptr     <= {PW{1'b0}};
            r_rptr     <= {PW{1'b0}};
            r_count    <= {(PW + 1){1'b0}};
            r_state    <= S_IDLE;
            r_clr_cnt  <= 9'd0;
            r_colour   <= 4'd0;
            r_clr_busy <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            if (w_store) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (w_range_err) begin
                r_wr_err <= 1'b1;
            end else if (err_clr) begin
                r_wr_err <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (clr_req) begin
                        r_state    <= S_CLEAR;
                        r_colour   <= clr_colour;
                        r_clr_cnt  <= 9'd0;
                        r_clr_busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (!mem_read) begin
                        if (r_clr_cnt == LAST_WORD) begin
                            r_state    <= S_IDLE;
                            r_clr_cnt  <= 9'd0;
                            r_clr_busy <= 1'b0;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + 9'd1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_clr_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/framebuffer_store.md
Name: framebuffer_store

Overview:
- Single-port pixel framebuffer holding one 64x48 frame of 4-bit pixels, packed 8 pixels per 32-bit word (384 words).
- Sits directly upstream of the row-buffering pixel feeder and serves its addr/pix_sel reads combinationally.
- Accepts host pixel writes through a valid/ready FIFO and performs a whole-frame clear.
- Writes never touch the array in a cycle where the feeder is reading (mem_read=1).

Parameters:
- FIFO_DEPTH, 4, host write FIFO entries (power of 2, >=2)
- H_PIX, 64, frame width in pixels (fixed; words per row = H_PIX/8)
- V_PIX, 48, frame height in pixels

Ports:
- clk_25  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- addr  in  9  feeder read word address = {y, x[5:3]} = y*8 + x/8
- pix_sel  in  3  feeder pixel-within-word select = x[2:0]
- mem_read  in  1  feeder is reading this cycle; array write forbidden
- pixel_in  out  4  selected pixel (feeds feeder's pixel_in), combinational
- wr_valid  in  1  host write request
- wr_ready  out  1  FIFO can accept
- wr_x  in  6  host pixel x
- wr_y  in  6  host pixel y
- wr_pix  in  4  host pixel value
- clr_req  in  1  pulse: start frame clear
- clr_colour  in  4  clear value, sampled when clr_req accepted
- clr_busy  out  1  clear in progress
- wr_err  out  1  sticky: out-of-range write dropped
- err_clr  in  1  clears wr_err

Behaviour:
- Array: 384 x 32 bits, not reset (contents undefined until written/cleared). Pixel p of word w occupies bits [4p+3:4p].
- Read path: pixel_in = word[addr] nibble pix_sel, purely combinational, zero latency, independent of FIFO/clear state. addr >= 384 -> pixel_in = 0.
- Reset values: wr_ready=1, clr_busy=0, wr_err=0, FIFO empty, state IDLE, clear counter 0.
- Host handshake: entry pushed on posedge when wr_valid && wr_ready. wr_ready = !full (registered count based). Push and pop in the same cycle allowed when full is not asserted; count unchanged.
- Range check at push: wr_y >= 48 -> entry not stored, wr_err set next cycle. wr_x is always in range. Handshake still completes (wr_ready unaffected).
- wr_err: sticky until err_clr. err_clr and a new error in the same cycle -> wr_err=1 (set wins).
- FSM states:
  - IDLE: if clr_req -> CLEAR (latch clr_colour, counter=0). Otherwise, if FIFO non-empty and mem_read=0, pop the head entry and read-modify-write one nibble of word {y,x[5:3]} on that posedge. Write is visible on pixel_in the next cycle.
  - CLEAR: each cycle with mem_read=0, write the replicated colour to word[counter] and increment the counter. Cycles with mem_read=1 stall (counter holds). After word 383 is written -> IDLE. FIFO pops are suspended; pushes continue.
  - clr_busy = (state==CLEAR), registered.
- Clear-start priority:
  - clr_req in IDLE takes priority over a pop in the same cycle.
  - Entries already queued are written after the clear completes, so they appear on top of the cleared image.
  - clr_req while in CLEAR is ignored (no restart).
- mem_read=1 blocks all array writes that cycle; reads are unaffected. This avoids port contention with the feeder's negedge capture.
- Reset mid-clear or with a non-empty FIFO aborts immediately: FIFO emptied, IDLE. Array keeps partially written contents.
- FIFO pointers are log2(FIFO_DEPTH) bits plus a separate count; they wrap modulo depth.

Test Plan:
- Reset, clr_req with clr_colour=4'hA, mem_read=0 -> clr_busy high for exactly 384 cycles, then every addr 0..383 / pix_sel 0..7 reads 4'hA.
- After clear to 0: write (x=13,y=5,pix=7) -> word 41 pix_sel 5 reads 7 one cycle after the pop. Neighbouring pix_sel 4 and 6 remain 0.
- Hold mem_read=1 and push 4 writes -> wr_ready=0 after the 4th, no array change. Drop mem_read -> one pop per cycle; all 4 pixels land and wr_ready returns to 1.
- Push y=48 -> wr_err=1 and the array is unchanged. Pulse err_clr -> wr_err=0. err_clr together with a new y=63 push -> wr_err stays 1.
- Start clear with 2 entries queued and toggle mem_read every other cycle -> clear takes 767 cycles. The queued pixels are written afterwards and read back over the clear colour.
- Assert rst at clear word 100 -> clr_busy=0 and wr_ready=1 immediately. Words 0..99 hold the clear colour.
